// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle CPU DM bus: word RAM with byte/half lane
// steering, post-reset zeroing sequencer and sticky capture of the first access error.
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR      = 32'h1001_0000,
    parameter int          DEPTH_WORDS    = 1024,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DM_E,
    input  logic        DM_R,
    input  logic        DM_W,
    input  logic [1:0]  opt,
    input  logic [31:0] addr,
    input  logic [31:0] DM_wdata,
    output logic [31:0] DM_rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] err_addr,
    output logic [1:0]  err_cause,
    output logic        state_dbg
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RANGE_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH_WORDS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt, clr_cnt_nxt;
    logic          clr_we;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          is_word, is_half, aligned, rw_both;
    logic          access, fault, wr_en, rd_en;
    logic [1:0]    fault_code;
    logic [3:0]    be;
    logic [31:0]   lane_wdata;
    logic [31:0]   rword, rsteer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RST_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we      = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == LAST_IDX) state_nxt = ST_READY;
            end
            ST_READY: ;
            default: state_nxt = RST_STATE;
        endcase
    end

    assign ready     = (state == ST_READY);
    assign state_dbg = state;

    // Bus contract: DM_E qualifies DM_R/DM_W every cycle and there is no stall. While
    // ready is low an enabled access is dropped silently (no write, rdata 0, no error).
    assign off      = addr - BASE_ADDR;
    assign in_range = off < RANGE_BYTES;
    assign idx      = off[AW+1:2];
    assign lane     = off[1:0];
    assign is_word  = opt[1];
    assign is_half  = (opt == 2'b01);
    assign aligned  = is_word ? (lane == 2'b00) : (is_half ? !lane[0] : 1'b1);
    assign rw_both  = DM_R & DM_W;

    assign access = DM_E & ready;
    assign fault  = access & (!in_range | !aligned | rw_both);
    assign wr_en  = access & !fault & DM_W;
    assign rd_en  = access & !fault & DM_R;

    always_comb begin
        fault_code = 2'b01;
        if (rw_both)        fault_code = 2'b11;
        else if (!in_range) fault_code = 2'b10;
    end

    always_comb begin
        be         = 4'b0000;
        lane_wdata = '0;
        if (is_word) begin
            be         = 4'b1111;
            lane_wdata = DM_wdata;
        end else if (is_half) begin
            be         = lane[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{DM_wdata[15:0]}};
        end else begin
            be         = 4'b0001 << lane;
            lane_wdata = {4{DM_wdata[7:0]}};
        end
    end

    // The clear sequencer and CPU writes share one port; they never overlap since CPU
    // writes need ready.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
            end
        end
    end

    assign rword = mem[idx];

    always_comb begin
        rsteer = rword;
        if (is_half) begin
            rsteer = {16'b0, lane[1] ? rword[31:16] : rword[15:0]};
        end else if (!is_word) begin
            case (lane)
                2'd0:    rsteer = {24'b0, rword[7:0]};
                2'd1:    rsteer = {24'b0, rword[15:8]};
                2'd2:    rsteer = {24'b0, rword[23:16]};
                default: rsteer = {24'b0, rword[31:24]};
            endcase
        end
    end

    assign DM_rdata = rd_en ? rsteer : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err       <= 1'b0;
            err_addr  <= '0;
            err_cause <= 2'b00;
        end else if (fault && !err) begin
            err       <= 1'b1;
            err_addr  <= addr;
            err_cause <= fault_code;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed lane/error/clear scenarios plus random accesses
// checked against a byte-addressed reference memory.
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 1024;
    localparam int          NBYTE = 4 * DEPTH;

    logic        clk;
    logic        rst;
    logic        DM_E, DM_R, DM_W;
    logic [1:0]  opt;
    logic [31:0] addr, DM_wdata;
    logic [31:0] DM_rdata;
    logic        ready, err;
    logic [31:0] err_addr;
    logic [1:0]  err_cause;
    logic        state_dbg;

    dmem_responder #(
        .BASE_ADDR(BASE),
        .DEPTH_WORDS(DEPTH),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .DM_E(DM_E),
        .DM_R(DM_R),
        .DM_W(DM_W),
        .opt(opt),
        .addr(addr),
        .DM_wdata(DM_wdata),
        .DM_rdata(DM_rdata),
        .ready(ready),
        .err(err),
        .err_addr(err_addr),
        .err_cause(err_cause),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: byte-addressed memory and error registers.
    logic [7:0]  mref [NBYTE];
    logic        m_ready;
    logic        m_err;
    logic [31:0] m_err_addr;
    logic [1:0]  m_err_cause;
    int          clr_bad_rdata;
    int          clr_bad_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [1:0] o);
        if (o[1]) return 4;
        if (o[0]) return 2;
        return 1;
    endfunction

    function automatic logic [1:0] ref_cause(input logic e, input logic r, input logic w,
                                             input logic [1:0] o, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (!e || !m_ready) return 2'b00;
        if (r && w) return 2'b11;
        if (off >= 32'(NBYTE)) return 2'b10;
        if ((off % 32'(size_of(o))) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_read(input logic e, input logic r, input logic w,
                                             input logic [1:0] o, input logic [31:0] a);
        logic [31:0] off, val;
        off = a - BASE;
        val = '0;
        if (!e || !r || !m_ready || ref_cause(e, r, w, o, a) != 2'b00) return '0;
        for (int k = 0; k < size_of(o); k++) val = val | (32'(mref[int'(off) + k]) << (8 * k));
        return val;
    endfunction

    task automatic ref_commit(input logic e, input logic r, input logic w,
                              input logic [1:0] o, input logic [31:0] a, input logic [31:0] wd);
        logic [1:0]  c;
        logic [31:0] off;
        c   = ref_cause(e, r, w, o, a);
        off = a - BASE;
        if (c != 2'b00) begin
            if (!m_err) begin
                m_err       = 1'b1;
                m_err_addr  = a;
                m_err_cause = c;
            end
        end else if (e && w && m_ready) begin
            for (int k = 0; k < size_of(o); k++) mref[int'(off) + k] = 8'(wd >> (8 * k));
        end
    endtask

    task automatic do_access(input logic e, input logic r, input logic w, input logic [1:0] o,
                             input logic [31:0] a, input logic [31:0] wd, output logic [31:0] obs);
        @(negedge clk);
        DM_E = e; DM_R = r; DM_W = w; opt = o; addr = a; DM_wdata = wd;
        #1;
        obs = DM_rdata;
        check("rdata", obs, ref_read(e, r, w, o, a));
        @(posedge clk);
        ref_commit(e, r, w, o, a, wd);
        #1;
        check("err", 32'(err), 32'(m_err));
        check("err_addr", err_addr, m_err_addr);
        check("err_cause", 32'(err_cause), 32'(m_err_cause));
    endtask

    task automatic apply_reset();
        DM_E = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
        #2 rst = 1'b0;
        #1;
        m_ready = 1'b0; m_err = 1'b0; m_err_addr = '0; m_err_cause = 2'b00;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_err_cause", 32'(err_cause), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Counts posedges after reset release until ready is seen, hammering the bus with
    // write attempts that must be ignored. stop_after>0 returns early after that many edges.
    task automatic run_clear(input int stop_after, output int rise);
        rise = 0;
        clr_bad_rdata = 0;
        clr_bad_err = 0;
        for (int i = 1; i <= 1100; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                DM_E = 1'b0;
                rise = i;
                break;
            end
            if (err) clr_bad_err++;
            if (i == stop_after) break;
            DM_E = 1'b1; DM_W = 1'b1; DM_R = 1'($urandom_range(0, 1));
            opt = 2'($urandom_range(0, 3));
            addr = BASE + 32'($urandom_range(0, NBYTE - 1));
            DM_wdata = $urandom();
            #1;
            if (DM_rdata != 32'd0) clr_bad_rdata++;
        end
        DM_E = 1'b0;
    endtask

    task automatic full_clear();
        int rise;
        run_clear(0, rise);
        check("clear_rise_edge", 32'(rise), 32'd1024);
        check("clear_rdata_zero", 32'(clr_bad_rdata), 32'd0);
        check("clear_no_err", 32'(clr_bad_err), 32'd0);
        m_ready = 1'b1;
        for (int k = 0; k < NBYTE; k++) mref[k] = 8'h00;
    endtask

    initial begin
        logic [31:0] obs;
        int          rise;
        logic        e, r, w;
        logic [1:0]  o;
        logic [31:0] a;
        int          k;

        rst = 1'b0; DM_E = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
        opt = 2'b00; addr = '0; DM_wdata = '0;
        m_ready = 1'b0; m_err = 1'b0; m_err_addr = '0; m_err_cause = 2'b00;
        #3;
        apply_reset();
        full_clear();

        do_access(1, 1, 0, 2'b11, 32'h1001_0FFC, 0, obs);
        check("lw_last_word", obs, 32'h0);
        do_access(1, 0, 1, 2'b11, 32'h1001_0010, 32'hDEADBEEF, obs);
        do_access(1, 1, 0, 2'b11, 32'h1001_0010, 0, obs);
        check("lw_word", obs, 32'hDEADBEEF);
        do_access(1, 0, 1, 2'b00, 32'h1001_0011, 32'h0000_005A, obs);
        do_access(1, 1, 0, 2'b11, 32'h1001_0010, 0, obs);
        check("lw_after_sb", obs, 32'hDEAD5AEF);
        do_access(1, 0, 1, 2'b01, 32'h1001_0012, 32'h0000_1234, obs);
        do_access(1, 1, 0, 2'b11, 32'h1001_0010, 0, obs);
        check("lw_after_sh", obs, 32'h12345AEF);
        do_access(1, 1, 0, 2'b01, 32'h1001_0012, 0, obs);
        check("lh_upper", obs, 32'h0000_1234);
        do_access(1, 1, 0, 2'b00, 32'h1001_0013, 0, obs);
        check("lb_lane3", obs, 32'h0000_0012);
        do_access(1, 1, 0, 2'b10, 32'h1001_0010, 0, obs);
        check("lw_opt10", obs, 32'h12345AEF);

        do_access(1, 0, 1, 2'b11, 32'h1001_0022, 32'hAAAA_BBBB, obs);
        check("misalign_err", 32'(err), 32'd1);
        check("misalign_addr", err_addr, 32'h1001_0022);
        check("misalign_cause", 32'(err_cause), 32'd1);
        do_access(1, 1, 0, 2'b11, 32'h1001_0020, 0, obs);
        check("misalign_no_write", obs, 32'h0);
        do_access(1, 1, 0, 2'b11, 32'h1001_1000, 0, obs);
        check("sticky_addr", err_addr, 32'h1001_0022);
        check("sticky_cause", 32'(err_cause), 32'd1);

        for (int n = 0; n < 400; n++) begin
            e = ($urandom_range(0, 9) != 0);
            k = $urandom_range(0, 19);
            r = (k < 10);
            w = (k == 0) || (k >= 10 && k < 18);
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       a = $urandom();
                1:       a = BASE + 32'(NBYTE) + 32'($urandom_range(0, 15));
                2:       a = BASE - 32'($urandom_range(1, 16));
                3:       a = BASE + 32'($urandom_range(0, NBYTE - 1));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            do_access(e, r, w, o, a, $urandom(), obs);
        end

        apply_reset();
        run_clear(500, rise);
        check("mid_clear_no_rise", 32'(rise), 32'd0);
        apply_reset();
        full_clear();
        do_access(1, 1, 0, 2'b11, 32'h1001_1000, 0, obs);
        check("oor_high_rdata", obs, 32'h0);
        check("oor_high_cause", 32'(err_cause), 32'd2);
        check("oor_high_addr", err_addr, 32'h1001_1000);

        apply_reset();
        full_clear();
        do_access(1, 1, 0, 2'b11, 32'h1000_FFFC, 0, obs);
        check("oor_low_rdata", obs, 32'h0);
        check("oor_low_cause", 32'(err_cause), 32'd2);

        apply_reset();
        full_clear();
        do_access(1, 1, 1, 2'b11, 32'h1001_0010, 32'hFFFF_FFFF, obs);
        check("rw_both_cause", 32'(err_cause), 32'd3);
        check("rw_both_rdata", obs, 32'h0);
        do_access(1, 1, 0, 2'b11, 32'h1001_0010, 0, obs);
        check("rw_both_no_write", obs, 32'h0);
        check("rw_both_sticky", 32'(err_cause), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle CPU's DM bus: DM_E/DM_R/DM_W, opt, address (alu_out) and DM_wdata.
- Provides a word-organised RAM with byte and halfword lane steering.
- Sub-word reads are returned right-justified; the CPU performs sign/zero extension.
- Adds a post-reset zeroing sequencer and sticky access-error capture, so software and the bench see deterministic memory and fault status.

Parameters:
BASE_ADDR, 32'h1001_0000, byte address mapped to word 0
DEPTH_WORDS, 1024, number of 32-bit words (power of two, >=4)
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting accesses; 0 = ready immediately

Ports:
clk  in  1  clock; all state updates on posedge (CPU updates pc on negedge)
rst  in  1  asynchronous reset, active-low
DM_E  in  1  access enable
DM_R  in  1  read request (qualified by DM_E)
DM_W  in  1  write request (qualified by DM_E)
opt  in  2  size {DM_32,DM_16}: 11 word, 01 half, 00 byte, 10 treated as word
addr  in  32  byte address
DM_wdata  in  32  write data, right-justified for byte/half
DM_rdata  out  32  read data, combinational
ready  out  1  1 = accesses are serviced
err  out  1  sticky access error
err_addr  out  32  address of the first erroring access
err_cause  out  2  01 misaligned, 10 out of range, 11 write while DM_R&DM_W both set

Behaviour:
- Reset: asserting rst low takes effect immediately, regardless of clk.
  - State -> CLEAR if CLEAR_ON_RESET, else READY.
  - ready=0 (or 1 if CLEAR_ON_RESET=0), clr_cnt=0, err=0, err_addr=0, err_cause=0.
  - RAM contents are not defined until CLEAR completes.
- State CLEAR (entered on rst release):
  - Each posedge writes 0 to word clr_cnt, then clr_cnt++.
  - After writing word DEPTH_WORDS-1, the next state is READY.
  - Total duration is exactly DEPTH_WORDS cycles; ready rises on the edge that writes the last word.
  - CPU accesses are ignored in CLEAR: no write, DM_rdata=0, no error logged.
  - A reset asserted mid-CLEAR restarts the clear from word 0.
- State READY: stays until reset.
- Decode:
  - off = addr - BASE_ADDR (32-bit wrap).
  - in_range = off < 4*DEPTH_WORDS.
  - idx = off[log2(DEPTH_WORDS)+1:2]; lane = off[1:0].
  - Aligned: word needs lane==00; half needs lane[0]==0; byte is always aligned.
- Valid access: DM_E & ready & in_range & aligned & !(DM_R & DM_W).
- Write (valid & DM_W), committed at posedge:
  - Word: all four bytes from DM_wdata.
  - Half: bytes {lane+1,lane} <= DM_wdata[15:0].
  - Byte: byte[lane] <= DM_wdata[7:0].
  - Other bytes of the word are unchanged.
  - Little-endian: byte 0 = bits [7:0].
- Read (valid & DM_R), combinational, zero latency:
  - Word: mem[idx].
  - Half: {16'b0, selected half}.
  - Byte: {24'b0, selected byte}.
  - Any other case: DM_rdata = 0.
  - A read in the same cycle as a write to the same word returns the pre-write value.
- Errors:
  - Trigger: DM_E & ready & (!in_range | !aligned | (DM_R & DM_W)).
  - Effect: suppresses the write and returns rdata 0.
  - If err==0 at the posedge: err<=1, err_addr<=addr, err_cause<=code.
  - Cause priority: 11 > 10 > 01.
  - Later errors do not overwrite the captured values; only reset clears them.
- DM_E=0: no effect; DM_rdata=0.
- The opt and addr offset arithmetic wraps modulo 2^32. Addresses below BASE_ADDR wrap to large offsets and report out of range.

Test Plan:
- Clear timing: rst low, then release with CLEAR_ON_RESET=1, DEPTH_WORDS=1024 -> ready stays 0 for 1023 edges and is 1 after edge 1024. A word read at 0x1001_0FFC then returns 0.
- Word write/read: SW 0xDEADBEEF to 0x1001_0010, then LW same address -> DM_rdata=0xDEADBEEF in the read cycle.
- Sub-word lanes:
  - After the word write, SB 0x5A at 0x1001_0011 -> LW returns 0xDEAD5AEF.
  - SH 0x1234 at 0x1001_0012 -> LW returns 0x12345AEF.
  - Half read at 0x1001_0012 returns 0x00001234; byte read at 0x1001_0013 returns 0x00000012.
- Misaligned: SW to 0x1001_0022 -> word 8 unchanged, err=1, err_addr=0x1001_0022, err_cause=01. A later out-of-range access leaves err_addr/err_cause unchanged.
- Out of range: LW at 0x1001_1000 and at 0x1000_FFFC -> DM_rdata=0, err_cause=10 on a fresh reset. Same-edge DM_R&DM_W -> cause 11, no write.
- Reset mid-operation: assert rst while clr_cnt=500, then release -> clear restarts and ready rises exactly 1024 cycles after release. SW attempts during CLEAR are dropped and err stays 0.
